// File: rtl/sprite_compositor.sv
// Sprite compositor: two-stage pixel pipeline over NUM_SPR double-buffered sprite channels.
// Frightened-sprite flashing is built in only when SPRITE_FLASH_EN is defined.
module sprite_compositor #(
  parameter int NUM_SPR      = 4,
  parameter int SPR_SIZE     = 8,
  parameter int COORD_W      = 10,
  parameter int FLASH_PERIOD = 15
) (
  input  logic                                Clk,
  input  logic                                Reset_n,
  input  logic [COORD_W-1:0]                  DrawX,
  input  logic [COORD_W-1:0]                  DrawY,
  input  logic                                pix_valid,
  input  logic                                frame_start,
  input  logic [23:0]                         bg_rgb,
  input  logic                                wr_en,
  input  logic [$clog2(NUM_SPR)-1:0]          wr_idx,
  input  logic [COORD_W-1:0]                  wr_x,
  input  logic [COORD_W-1:0]                  wr_y,
  input  logic                                wr_show,
  input  logic                                wr_fright,
  input  logic [23:0]                         wr_rgb,
  input  logic                                flash_req,
  output logic [NUM_SPR*$clog2(SPR_SIZE)-1:0] spr_row_addr,
  input  logic [NUM_SPR*SPR_SIZE-1:0]         spr_row_data,
  output logic [23:0]                         rgb_out,
  output logic                                rgb_valid,
  output logic                                hit_any,
  output logic [$clog2(NUM_SPR)-1:0]          hit_idx,
  output logic [NUM_SPR-2:0]                  coll_frame
);

  localparam int IW = $clog2(NUM_SPR);
  localparam int AW = $clog2(SPR_SIZE);
  localparam logic [23:0] BLUE  = 24'h0000FF;
  localparam logic [23:0] WHITE = 24'hFFFFFF;

  logic [23:0]        fright_col;
  logic [NUM_SPR-1:0] opaque;
  logic [NUM_SPR-2:0] hits;
  logic [23:0]        s1_col [NUM_SPR];
  logic               s1_valid_reg;
  logic [23:0]        s1_bg_reg;
  logic [NUM_SPR-2:0] coll_reg;

`ifdef SPRITE_FLASH_EN
  logic [7:0] flash_cnt_reg;
  logic       flash_phase_reg;

  always_ff @(posedge Clk) begin
    if (!Reset_n || !flash_req) begin
      flash_cnt_reg   <= 8'd0;
      flash_phase_reg <= 1'b0;
    end else if (frame_start) begin
      if (flash_cnt_reg == 8'(FLASH_PERIOD - 1)) begin
        flash_cnt_reg   <= 8'd0;
        flash_phase_reg <= ~flash_phase_reg;
      end else begin
        flash_cnt_reg <= flash_cnt_reg + 8'd1;
      end
    end
  end

  // Gate with flash_req so a dropped request shows blue on the very next pixel.
  assign fright_col = (flash_req && flash_phase_reg) ? WHITE : BLUE;
`else
  logic [8:0] unused_flash_cfg;
  assign unused_flash_cfg = {flash_req, 8'(FLASH_PERIOD)};
  assign fright_col       = BLUE;
`endif

  for (genvar gi = 0; gi < NUM_SPR; gi++) begin : g_chan
    logic [COORD_W-1:0]  sh_x_reg, sh_y_reg, act_x_reg, act_y_reg;
    logic                sh_show_reg, sh_fright_reg, act_show_reg, act_fright_reg;
    logic [23:0]         sh_rgb_reg, act_rgb_reg;
    logic [COORD_W:0]    dx_full, dy_full;
    logic                in_box;
    logic                box_reg;
    logic [AW-1:0]       dx_reg, dy_reg;
    logic [23:0]         col_reg;
    logic [SPR_SIZE-1:0] row;

    // A borrow means the pixel lies left of / above the origin: clip instead of wrapping.
    assign dx_full = {1'b0, DrawX} - {1'b0, act_x_reg};
    assign dy_full = {1'b0, DrawY} - {1'b0, act_y_reg};
    assign in_box  = act_show_reg && !dx_full[COORD_W] && !dy_full[COORD_W]
                  && (dx_full[COORD_W-1:0] < COORD_W'(SPR_SIZE))
                  && (dy_full[COORD_W-1:0] < COORD_W'(SPR_SIZE));

    always_ff @(posedge Clk) begin
      if (!Reset_n) begin
        sh_x_reg       <= '0;
        sh_y_reg       <= '0;
        sh_show_reg    <= 1'b0;
        sh_fright_reg  <= 1'b0;
        sh_rgb_reg     <= 24'h0;
        act_x_reg      <= '0;
        act_y_reg      <= '0;
        act_show_reg   <= 1'b0;
        act_fright_reg <= 1'b0;
        act_rgb_reg    <= 24'h0;
        box_reg        <= 1'b0;
        dx_reg         <= '0;
        dy_reg         <= '0;
        col_reg        <= 24'h0;
      end else begin
        if (frame_start) begin
          act_x_reg      <= sh_x_reg;
          act_y_reg      <= sh_y_reg;
          act_show_reg   <= sh_show_reg;
          act_fright_reg <= sh_fright_reg;
          act_rgb_reg    <= sh_rgb_reg;
        end
        if (wr_en && wr_idx == IW'(gi)) begin
          sh_x_reg      <= wr_x;
          sh_y_reg      <= wr_y;
          sh_show_reg   <= wr_show;
          sh_fright_reg <= wr_fright;
          sh_rgb_reg    <= wr_rgb;
        end
        box_reg <= in_box;
        dx_reg  <= dx_full[AW-1:0];
        dy_reg  <= dy_full[AW-1:0];
        col_reg <= act_fright_reg ? fright_col : act_rgb_reg;
      end
    end

    assign row                       = spr_row_data[gi*SPR_SIZE +: SPR_SIZE];
    assign spr_row_addr[gi*AW +: AW] = dy_reg;
    // MSB is the leftmost pixel, so column dx lives at bit SPR_SIZE-1-dx == ~dx.
    assign opaque[gi] = box_reg && row[~dx_reg];
    assign s1_col[gi] = col_reg;

    if (gi > 0) begin : g_hit
      assign hits[gi-1] = s1_valid_reg && opaque[0] && opaque[gi];
    end
  end

  logic          win_any;
  logic [IW-1:0] win_idx;
  logic [23:0]   win_col;

  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    win_col = s1_bg_reg;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        win_any = 1'b1;
        win_idx = IW'(i);
        win_col = s1_col[i];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_valid_reg <= 1'b0;
      s1_bg_reg    <= 24'h0;
      rgb_valid    <= 1'b0;
      rgb_out      <= 24'h0;
      hit_any      <= 1'b0;
      hit_idx      <= '0;
      coll_reg     <= '0;
      coll_frame   <= '0;
    end else begin
      s1_valid_reg <= pix_valid;
      s1_bg_reg    <= bg_rgb;
      rgb_valid    <= s1_valid_reg;
      rgb_out      <= s1_valid_reg ? win_col : 24'h0;
      hit_any      <= s1_valid_reg && win_any;
      hit_idx      <= s1_valid_reg ? win_idx : '0;
      // A hit coinciding with frame_start belongs to the frame that is starting.
      if (frame_start) begin
        coll_frame <= coll_reg;
        coll_reg   <= hits;
      end else begin
        coll_reg <= coll_reg | hits;
      end
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: directed scenarios plus randomized traffic
// compared every cycle against a pixel-level reference model.
`timescale 1ns/1ps
module tb_sprite_compositor;
  localparam int NS = 4;
  localparam int SZ = 8;
  localparam int CW = 10;
  localparam int FP = 2;
  localparam logic [23:0] BLUE  = 24'h0000FF;
  localparam logic [23:0] WHITE = 24'hFFFFFF;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic [CW-1:0] DrawX, DrawY;
  logic          pix_valid, frame_start;
  logic [23:0]   bg_rgb;
  logic          wr_en;
  logic [1:0]    wr_idx;
  logic [CW-1:0] wr_x, wr_y;
  logic          wr_show, wr_fright;
  logic [23:0]   wr_rgb;
  logic          flash_req;
  logic [NS*3-1:0]  spr_row_addr;
  logic [NS*SZ-1:0] spr_row_data;
  logic [23:0]   rgb_out;
  logic          rgb_valid, hit_any;
  logic [1:0]    hit_idx;
  logic [NS-2:0] coll_frame;

  always #5 Clk = ~Clk;

  sprite_compositor #(.NUM_SPR(NS), .SPR_SIZE(SZ), .COORD_W(CW), .FLASH_PERIOD(FP)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .pix_valid(pix_valid),
    .frame_start(frame_start), .bg_rgb(bg_rgb), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_x(wr_x), .wr_y(wr_y), .wr_show(wr_show), .wr_fright(wr_fright), .wr_rgb(wr_rgb),
    .flash_req(flash_req), .spr_row_addr(spr_row_addr), .spr_row_data(spr_row_data),
    .rgb_out(rgb_out), .rgb_valid(rgb_valid), .hit_any(hit_any), .hit_idx(hit_idx),
    .coll_frame(coll_frame)
  );

  // External bitmap ROM
  logic [SZ-1:0] rom [NS][SZ];
  always_comb begin
    spr_row_data = '0;
    for (int c = 0; c < NS; c++) spr_row_data[c*SZ +: SZ] = rom[c][spr_row_addr[c*3 +: 3]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, got, want, $time);
    end
  endtask

  // Reference model: sprite tables, frame counter, and the pixel result two cycles out
  logic [CW-1:0] m_sx [NS], m_sy [NS], m_ax [NS], m_ay [NS];
  logic          m_ss [NS], m_sf [NS], m_as [NS], m_af [NS];
  logic [23:0]   m_srgb [NS], m_argb [NS];
  logic [NS-2:0] m_coll = '0, e_cf = '0, p_hits = '0;
  int            fcount = 0;
  logic          p_v = 1'b0, p_any = 1'b0, e_v = 1'b0, e_any = 1'b0;
  int            p_idx = 0, e_idx = 0;
  logic [23:0]   p_rgb = 24'h0, e_rgb = 24'h0;

  task automatic model_pixel();
    logic [NS-1:0] op;
    logic [23:0]   fr;
    int            ddx, ddy;
`ifdef SPRITE_FLASH_EN
    fr = (flash_req && ((fcount / FP) % 2 == 1)) ? WHITE : BLUE;
`else
    fr = BLUE;
`endif
    op = '0;
    for (int i = 0; i < NS; i++) begin
      ddx = int'(DrawX) - int'(m_ax[i]);
      ddy = int'(DrawY) - int'(m_ay[i]);
      if (m_as[i] && ddx >= 0 && ddx < SZ && ddy >= 0 && ddy < SZ) op[i] = rom[i][ddy][SZ-1-ddx];
    end
    p_v    = pix_valid;
    p_any  = 1'b0;
    p_idx  = 0;
    p_rgb  = pix_valid ? bg_rgb : 24'h0;
    p_hits = '0;
    if (pix_valid) begin
      for (int i = 0; i < NS; i++) begin
        if (op[i] && !p_any) begin
          p_any = 1'b1;
          p_idx = i;
          p_rgb = m_af[i] ? fr : m_argb[i];
        end
      end
      for (int i = 1; i < NS; i++) p_hits[i-1] = op[0] & op[i];
    end
  endtask

  initial begin
    forever begin
      @(posedge Clk);
      if (Reset_n !== 1'b1) begin
        for (int i = 0; i < NS; i++) begin
          m_sx[i] = '0; m_sy[i] = '0; m_ss[i] = 1'b0; m_sf[i] = 1'b0; m_srgb[i] = 24'h0;
          m_ax[i] = '0; m_ay[i] = '0; m_as[i] = 1'b0; m_af[i] = 1'b0; m_argb[i] = 24'h0;
        end
        m_coll = '0; e_cf = '0; p_hits = '0; fcount = 0;
        p_v = 1'b0; p_any = 1'b0; p_idx = 0; p_rgb = 24'h0;
        e_v = 1'b0; e_any = 1'b0; e_idx = 0; e_rgb = 24'h0;
      end else begin
        e_v = p_v; e_any = p_any; e_idx = p_idx; e_rgb = p_rgb;
        if (frame_start) begin
          e_cf   = m_coll;
          m_coll = p_hits;
        end else begin
          m_coll = m_coll | p_hits;
        end
        model_pixel();
        if (frame_start) begin
          for (int i = 0; i < NS; i++) begin
            m_ax[i] = m_sx[i]; m_ay[i] = m_sy[i]; m_as[i] = m_ss[i];
            m_af[i] = m_sf[i]; m_argb[i] = m_srgb[i];
          end
        end
        if (wr_en) begin
          m_sx[wr_idx] = wr_x; m_sy[wr_idx] = wr_y; m_ss[wr_idx] = wr_show;
          m_sf[wr_idx] = wr_fright; m_srgb[wr_idx] = wr_rgb;
        end
        if (!flash_req) fcount = 0;
        else if (frame_start) fcount++;
      end
    end
  end

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge Clk);
      check("cyc.rgb_valid", rgb_valid, e_v);
      check("cyc.rgb_out", rgb_out, e_rgb);
      check("cyc.hit_any", hit_any, e_any);
      if (e_any) check("cyc.hit_idx", hit_idx, e_idx);
      check("cyc.coll_frame", coll_frame, e_cf);
    end
  end

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic wr(input int idx, input int x, input int y, input logic sh, input logic fr,
                    input logic [23:0] c);
    wr_en = 1'b1; wr_idx = 2'(idx); wr_x = CW'(x); wr_y = CW'(y);
    wr_show = sh; wr_fright = fr; wr_rgb = c;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pix_chk(input string nm, input int x, input int y, input logic [23:0] bg,
                         input logic [23:0] er, input logic eh, input int ei);
    DrawX = CW'(x); DrawY = CW'(y); bg_rgb = bg; pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    tick();
    check({nm, ".valid"}, rgb_valid, 1);
    check({nm, ".rgb"}, rgb_out, er);
    check({nm, ".hit_any"}, hit_any, eh);
    if (eh) check({nm, ".hit_idx"}, hit_idx, ei);
    $display("pixel %s (%0d,%0d): rgb=%h hit_any=%0d hit_idx=%0d", nm, x, y, rgb_out, hit_any, hit_idx);
  endtask

  logic [23:0] flash_seq [7];
  logic [23:0] bg;

  initial begin
`ifdef SPRITE_FLASH_EN
    flash_seq = '{BLUE, BLUE, WHITE, WHITE, BLUE, BLUE, WHITE};
`else
    flash_seq = '{BLUE, BLUE, BLUE, BLUE, BLUE, BLUE, BLUE};
`endif
    bg = 24'h123456;
    Reset_n = 1'b0; DrawX = '0; DrawY = '0; pix_valid = 1'b0; frame_start = 1'b0;
    bg_rgb = 24'h0; wr_en = 1'b0; wr_idx = '0; wr_x = '0; wr_y = '0; wr_show = 1'b0;
    wr_fright = 1'b0; wr_rgb = 24'h0; flash_req = 1'b0;
    for (int c = 0; c < NS; c++) for (int r = 0; r < SZ; r++) rom[c][r] = 8'hFF;
    repeat (3) tick();
    check("reset.rgb_valid", rgb_valid, 0);
    check("reset.rgb_out", rgb_out, 0);
    check("reset.hit_any", hit_any, 0);
    check("reset.hit_idx", hit_idx, 0);
    check("reset.coll_frame", coll_frame, 0);
    $display("reset: rgb_valid=%0d rgb_out=%h coll_frame=%b", rgb_valid, rgb_out, coll_frame);
    Reset_n = 1'b1;
    tick();

    wr(1, 100, 50, 1'b1, 1'b0, 24'hFF0000);
    frame();
    pix_chk("s1_inside", 103, 52, bg, 24'hFF0000, 1'b1, 1);
    pix_chk("s1_right_out", 108, 52, bg, bg, 1'b0, 0);

    wr(0, 200, 200, 1'b1, 1'b0, 24'h00FF00);
    wr(2, 200, 200, 1'b1, 1'b0, 24'h0000AA);
    frame();
    pix_chk("tie_player", 201, 201, 24'h0, 24'h00FF00, 1'b1, 0);
    frame();
    check("coll_frame_tie", coll_frame, 3'b010);
    frame();
    check("coll_frame_clear", coll_frame, 3'b000);
    $display("collision: coll_frame=%b", coll_frame);

    wr_en = 1'b1; wr_idx = 2'd1; wr_x = CW'(300); wr_y = CW'(50); wr_show = 1'b1;
    wr_fright = 1'b0; wr_rgb = 24'hFF0000; frame_start = 1'b1;
    tick();
    wr_en = 1'b0; frame_start = 1'b0;
    pix_chk("old_pos_kept", 103, 52, bg, 24'hFF0000, 1'b1, 1);
    pix_chk("new_pos_early", 301, 52, bg, bg, 1'b0, 0);
    frame();
    pix_chk("new_pos", 301, 52, bg, 24'hFF0000, 1'b1, 1);
    pix_chk("old_pos_gone", 103, 52, bg, bg, 1'b0, 0);

    wr(3, 1020, 10, 1'b1, 1'b0, 24'h00AB00);
    frame();
    pix_chk("no_wrap", 2, 12, bg, bg, 1'b0, 0);
    pix_chk("right_clip_hit", 1023, 12, bg, 24'h00AB00, 1'b1, 3);

    wr(3, 1020, 10, 1'b1, 1'b1, 24'h00AB00);
    frame();
    flash_req = 1'b1;
    pix_chk("flash_f0", 1021, 12, bg, flash_seq[0], 1'b1, 3);
    for (int k = 1; k < 7; k++) begin
      frame();
      pix_chk($sformatf("flash_f%0d", k), 1021, 12, bg, flash_seq[k], 1'b1, 3);
    end
    flash_req = 1'b0;
    pix_chk("flash_drop", 1021, 12, bg, BLUE, 1'b1, 3);

    bg_rgb = 24'h0A0B0C; DrawY = CW'(52);
    for (int k = 0; k < 5; k++) begin
      DrawX = CW'(301 + k); pix_valid = 1'b1; Reset_n = (k != 2);
      tick();
      if (k == 2 || k == 3) check($sformatf("reset_flush%0d", k), rgb_valid, 0);
      if (k == 4) begin
        check("post_reset.valid", rgb_valid, 1);
        check("post_reset.rgb", rgb_out, 24'h0A0B0C);
        check("post_reset.hit_any", hit_any, 0);
      end
    end
    pix_valid = 1'b0;
    tick();
    $display("reset burst: rgb_valid=%0d rgb_out=%h", rgb_valid, rgb_out);
    pix_chk("hidden_after_reset", 301, 52, bg, bg, 1'b0, 0);
    frame();
    pix_chk("hidden_after_frame", 301, 52, bg, bg, 1'b0, 0);
    wr(1, 300, 50, 1'b1, 1'b0, 24'hFF0000);
    pix_chk("written_no_frame", 301, 52, bg, bg, 1'b0, 0);
    frame();
    pix_chk("rewritten", 301, 52, bg, 24'hFF0000, 1'b1, 1);

    repeat (3) tick();
    for (int c = 0; c < NS; c++) for (int r = 0; r < SZ; r++) rom[c][r] = 8'($urandom);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      Reset_n     = ($urandom_range(0, 499) != 0);
      frame_start = ($urandom_range(0, 39) == 0);
      if (frame_start && $urandom_range(0, 3) == 0) flash_req = ~flash_req;
      wr_en     = ($urandom_range(0, 9) < 3);
      wr_idx    = 2'($urandom_range(0, 3));
      wr_x      = ($urandom_range(0, 5) == 0) ? CW'(1016 + $urandom_range(0, 7)) : CW'($urandom_range(0, 40));
      wr_y      = CW'($urandom_range(0, 40));
      wr_show   = ($urandom_range(0, 3) != 0);
      wr_fright = ($urandom_range(0, 3) == 0);
      wr_rgb    = 24'($urandom);
      pix_valid = ($urandom_range(0, 9) < 8);
      DrawX     = ($urandom_range(0, 3) == 0) ? CW'(1012 + $urandom_range(0, 11)) : CW'($urandom_range(0, 50));
      DrawY     = CW'($urandom_range(0, 50));
      bg_rgb    = 24'($urandom);
      tick();
    end
    Reset_n = 1'b1; pix_valid = 1'b0; wr_en = 1'b0; frame_start = 1'b0;
    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
